// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Two-port (instruction / data) line arbiter in front of a single
//            emulated memory. One transaction in flight at a time, round-robin
//            on ties, fixed MEM_LATENCY access time, one-cycle ready pulses.
// Ports    : clk, reset            - clock, synchronous active-high reset
//            ic_req/ic_addr        - instruction read request (level)
//            ic_ready/ic_data      - instruction completion pulse / read line
//            dc_req/dc_we/dc_addr/dc_wdata - data request (read or write)
//            dc_ready/dc_rdata     - data completion pulse / read line
//            mem_rd_addr/mem_rdata - memory read port (rdata combinational)
//            mem_wr_addr/mem_wdata/mem_we - memory write port
//            busy                  - transaction in flight (BUSY or RESP)
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W      = 20,
    parameter int LINE_W      = 128,
    parameter int MEM_LATENCY = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_ready,
    output logic [LINE_W-1:0] ic_data,
    input  logic              dc_req,
    input  logic              dc_we,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [LINE_W-1:0] dc_wdata,
    output logic              dc_ready,
    output logic [LINE_W-1:0] dc_rdata,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [LINE_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [LINE_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              busy
);

    // Four bits cover the whole legal latency range 1..15.
    localparam int               c_CNT_W    = 4;
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_owner_dc;   // 1 = data side owns the transaction
    logic                r_last_dc;    // 1 = data side received the last grant
    logic [ADDR_W-1:0]   r_addr;
    logic                r_we;
    logic [LINE_W-1:0]   r_wdata;
    logic [LINE_W-1:0]   r_ic_data;
    logic [LINE_W-1:0]   r_dc_rdata;
    logic                r_ic_ready;
    logic                r_dc_ready;

    logic                w_any_req;
    logic                w_grant_dc;
    logic                w_mem_cycle;

    assign w_any_req   = ic_req | dc_req;
    // Data side wins when alone, or on a tie when the instruction side had
    // the previous grant.
    assign w_grant_dc  = dc_req & (~ic_req | ~r_last_dc);
    // The final BUSY cycle is the one in which memory is actually accessed.
    assign w_mem_cycle = (r_state == ST_BUSY) && (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_owner_dc <= 1'b0;
            r_last_dc  <= 1'b1;
            r_addr     <= '0;
            r_we       <= 1'b0;
            r_wdata    <= '0;
            r_ic_data  <= '0;
            r_dc_rdata <= '0;
            r_ic_ready <= 1'b0;
            r_dc_ready <= 1'b0;
        end else begin
            r_ic_ready <= 1'b0;
            r_dc_ready <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_owner_dc <= w_grant_dc;
                        r_last_dc  <= w_grant_dc;
                        r_addr     <= w_grant_dc ? dc_addr : ic_addr;
                        r_we       <= w_grant_dc & dc_we;
                        r_wdata    <= w_grant_dc ? dc_wdata : '0;
                        r_cnt      <= c_CNT_LOAD;
                        r_state    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (r_cnt == '0) begin
                        if (!r_we) begin
                            if (r_owner_dc) begin
                                r_dc_rdata <= mem_rdata;
                            end else begin
                                r_ic_data <= mem_rdata;
                            end
                        end
                        // Ready is registered so it is high during RESP only.
                        r_ic_ready <= ~r_owner_dc;
                        r_dc_ready <= r_owner_dc;
                        r_state    <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ic_ready    = r_ic_ready;
    assign dc_ready    = r_dc_ready;
    assign ic_data     = r_ic_data;
    assign dc_rdata    = r_dc_rdata;
    assign busy        = (r_state != ST_IDLE);
    assign mem_rd_addr = (r_state == ST_BUSY) ? r_addr : '0;
    assign mem_we      = w_mem_cycle & r_we;
    assign mem_wr_addr = mem_we ? r_addr  : '0;
    assign mem_wdata   = mem_we ? r_wdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Directed self-checking bench for mem_arbiter. A second instance
//            with MEM_LATENCY=1 covers the shortest latency. Memory model:
//            the line at address a holds words a..a+3, word n = 0xDA7A0000+n.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    logic         clk;
    logic         reset;
    logic         ic_req;
    logic [19:0]  ic_addr;
    logic         ic_ready;
    logic [127:0] ic_data;
    logic         dc_req;
    logic         dc_we;
    logic [19:0]  dc_addr;
    logic [127:0] dc_wdata;
    logic         dc_ready;
    logic [127:0] dc_rdata;
    logic [19:0]  mem_rd_addr;
    logic [127:0] mem_rdata;
    logic [19:0]  mem_wr_addr;
    logic [127:0] mem_wdata;
    logic         mem_we;
    logic         busy;

    logic         ic_req1;
    logic [19:0]  ic_addr1;
    logic         ic_ready1;
    logic [127:0] ic_data1;
    logic         dc_req1;
    logic         dc_we1;
    logic [19:0]  dc_addr1;
    logic [127:0] dc_wdata1;
    logic         dc_ready1;
    logic [127:0] dc_rdata1;
    logic [19:0]  mem_rd_addr1;
    logic [127:0] mem_rdata1;
    logic [19:0]  mem_wr_addr1;
    logic [127:0] mem_wdata1;
    logic         mem_we1;
    logic         busy1;

    function automatic logic [127:0] line_of(input logic [19:0] a);
        logic [127:0] l;
        for (int k = 0; k < 4; k++) begin
            l[k*32 +: 32] = 32'hDA7A_0000 + 32'(a) + 32'(k);
        end
        return l;
    endfunction

    assign mem_rdata  = line_of(mem_rd_addr);
    assign mem_rdata1 = line_of(mem_rd_addr1);

    mem_arbiter #(.ADDR_W(20), .LINE_W(128), .MEM_LATENCY(5)) u_dut (
        .clk(clk), .reset(reset),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_ready(ic_ready), .ic_data(ic_data),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_ready(dc_ready), .dc_rdata(dc_rdata),
        .mem_rd_addr(mem_rd_addr), .mem_rdata(mem_rdata),
        .mem_wr_addr(mem_wr_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .busy(busy)
    );

    mem_arbiter #(.ADDR_W(20), .LINE_W(128), .MEM_LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .ic_req(ic_req1), .ic_addr(ic_addr1), .ic_ready(ic_ready1), .ic_data(ic_data1),
        .dc_req(dc_req1), .dc_we(dc_we1), .dc_addr(dc_addr1), .dc_wdata(dc_wdata1),
        .dc_ready(dc_ready1), .dc_rdata(dc_rdata1),
        .mem_rd_addr(mem_rd_addr1), .mem_rdata(mem_rdata1),
        .mem_wr_addr(mem_wr_addr1), .mem_wdata(mem_wdata1), .mem_we(mem_we1),
        .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Per-test observation state, cleared by clear_stats.
    int           rel, ic_n, dc_n, ic_cyc, dc_cyc, we_n, we_cyc, busy_st, rd_bad, wr_bad, ev_n;
    int           ev_cyc[8];
    bit           ev_dc[8];
    logic [19:0]  we_addr, exp_rd;
    logic [127:0] we_data;
    bit           auto_drop;

    task automatic clear_stats();
        rel = 0; ic_n = 0; dc_n = 0; ic_cyc = -1; dc_cyc = -1;
        we_n = 0; we_cyc = -1; busy_st = 0; rd_bad = 0; wr_bad = 0; ev_n = 0;
        we_addr = '0; we_data = '0;
        for (int i = 0; i < 8; i++) begin
            ev_cyc[i] = -1;
            ev_dc[i]  = 1'b0;
        end
    endtask

    // Observe n cycles at the falling edge; rel numbers them from the grant.
    task automatic watch(input int n);
        bit in_busy;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            rel++;
            in_busy = busy && !ic_ready && !dc_ready;
            if (in_busy) busy_st++;
            if (mem_rd_addr !== (in_busy ? exp_rd : 20'h0)) rd_bad++;
            if (!mem_we && (mem_wr_addr !== 20'h0 || mem_wdata !== 128'h0)) wr_bad++;
            if (ic_ready) begin
                ic_n++; ic_cyc = rel;
                if (ev_n < 8) begin ev_cyc[ev_n] = rel; ev_dc[ev_n] = 1'b0; ev_n++; end
                if (auto_drop) ic_req = 1'b0;
            end
            if (dc_ready) begin
                dc_n++; dc_cyc = rel;
                if (ev_n < 8) begin ev_cyc[ev_n] = rel; ev_dc[ev_n] = 1'b1; ev_n++; end
                if (auto_drop) dc_req = 1'b0;
            end
            if (mem_we) begin
                we_n++; we_cyc = rel; we_addr = mem_wr_addr; we_data = mem_wdata;
            end
        end
    endtask

    // Leaves the bench at a falling edge with reset low and the FSM in IDLE.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; ic_req = 1'b0; dc_req = 1'b0; ic_req1 = 1'b0; dc_req1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int b1, r1cyc;
        reset = 1'b1;
        ic_req = 0; ic_addr = '0; dc_req = 0; dc_we = 0; dc_addr = '0; dc_wdata = '0;
        ic_req1 = 0; ic_addr1 = '0; dc_req1 = 0; dc_we1 = 0; dc_addr1 = '0; dc_wdata1 = '0;
        exp_rd = '0; auto_drop = 1'b1;
        clear_stats();

        // Reset state
        do_reset();
        chk("rst_busy",     busy,        0);
        chk("rst_ready",    {ic_ready, dc_ready}, 0);
        chk("rst_ic_data",  ic_data,     0);
        chk("rst_dc_rdata", dc_rdata,    0);
        chk("rst_mem",      {mem_we, mem_rd_addr, mem_wr_addr}, 0);
        chk("rst_wdata",    mem_wdata,   0);

        // IC read of line 4
        ic_req = 1'b1; ic_addr = 20'h00004; exp_rd = 20'h00004;
        clear_stats();
        watch(8);
        chk("ic_rd_ready_cyc", ic_cyc, 6);
        chk("ic_rd_ready_n",   ic_n,   1);
        chk("ic_rd_dc_n",      dc_n,   0);
        chk("ic_rd_we_n",      we_n,   0);
        chk("ic_rd_busy_cyc",  busy_st, 5);
        chk("ic_rd_rdaddr",    rd_bad, 0);
        chk("ic_rd_data",      ic_data, 128'hDA7A0007_DA7A0006_DA7A0005_DA7A0004);

        // DC write of line 0x100
        dc_req = 1'b1; dc_we = 1'b1; dc_addr = 20'h00100;
        dc_wdata = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        exp_rd = 20'h00100;
        clear_stats();
        watch(8);
        chk("dc_wr_we_n",     we_n,   1);
        chk("dc_wr_we_cyc",   we_cyc, 5);
        chk("dc_wr_we_addr",  we_addr, 20'h00100);
        chk("dc_wr_we_data",  we_data, 128'h1111_2222_3333_4444_5555_6666_7777_8888);
        chk("dc_wr_ready",    dc_cyc, 6);
        chk("dc_wr_ready_n",  dc_n,   1);
        chk("dc_wr_wr_idle",  wr_bad, 0);
        chk("dc_wr_rdata",    dc_rdata, 0);
        chk("dc_wr_ic_hold",  ic_data, 128'hDA7A0007_DA7A0006_DA7A0005_DA7A0004);

        // Both sides requesting continuously: IC, DC, IC, DC
        do_reset();
        dc_we = 1'b0; dc_wdata = '0;
        ic_req = 1'b1; ic_addr = 20'h00010;
        dc_req = 1'b1; dc_addr = 20'h00020;
        auto_drop = 1'b0;
        clear_stats();
        watch(28);
        ic_req = 1'b0; dc_req = 1'b0;
        auto_drop = 1'b1;
        chk("rr_events", ev_n, 4);
        chk("rr_order",  {ev_dc[0], ev_dc[1], ev_dc[2], ev_dc[3]}, 4'b0101);
        chk("rr_cyc0",   ev_cyc[0], 6);
        chk("rr_cyc1",   ev_cyc[1], 13);
        chk("rr_cyc2",   ev_cyc[2], 20);
        chk("rr_cyc3",   ev_cyc[3], 27);
        chk("rr_ic_data", ic_data,  128'hDA7A0013_DA7A0012_DA7A0011_DA7A0010);
        chk("rr_dc_data", dc_rdata, 128'hDA7A0023_DA7A0022_DA7A0021_DA7A0020);
        chk("rr_we_n",    we_n, 0);
        watch(8);

        // Reset in the middle of a DC write
        do_reset();
        dc_req = 1'b1; dc_we = 1'b1; dc_addr = 20'h00200; dc_wdata = {4{32'hCAFE_F00D}};
        exp_rd = 20'h00200;
        clear_stats();
        watch(3);
        reset = 1'b1; dc_req = 1'b0;
        watch(1);
        chk("rst_mid_busy",  busy, 0);
        chk("rst_mid_mem",   {mem_we, mem_rd_addr, mem_wr_addr, dc_ready}, 0);
        chk("rst_mid_wdata", mem_wdata, 0);
        reset = 1'b0;
        watch(8);
        chk("rst_mid_we_n",  we_n, 0);
        chk("rst_mid_rdy_n", dc_n, 0);

        // IC address changed and request dropped after grant
        do_reset();
        ic_req = 1'b1; ic_addr = 20'h00030; exp_rd = 20'h00030;
        clear_stats();
        watch(2);
        ic_addr = 20'h00055; ic_req = 1'b0;
        watch(6);
        chk("drop_ready_cyc", ic_cyc, 6);
        chk("drop_ready_n",   ic_n, 1);
        chk("drop_rdaddr",    rd_bad, 0);
        chk("drop_data",      ic_data, 128'hDA7A0033_DA7A0032_DA7A0031_DA7A0030);

        // MEM_LATENCY=1 DC read
        do_reset();
        dc_req1 = 1'b1; dc_we1 = 1'b0; dc_addr1 = 20'h00040;
        b1 = 0; r1cyc = -1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (busy1 && !dc_ready1) b1++;
            if (dc_ready1) begin r1cyc = c; dc_req1 = 1'b0; end
        end
        chk("lat1_busy_cyc", b1, 1);
        chk("lat1_ready",    r1cyc, 2);
        chk("lat1_data",     dc_rdata1, 128'hDA7A0043_DA7A0042_DA7A0041_DA7A0040);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
